// File: rtl/rr_sel_arbiter.sv
// Round-robin select generator for an N-way mux: grants one requester at a time,
// holds until done / request drop / hold limit, then forces one idle bubble.
module rr_sel_arbiter #(
    parameter int SEL_WIDTH = 2,
    parameter int HOLD_MAX  = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [2**SEL_WIDTH-1:0]   i_req,
    input  logic                      i_done,
    output logic [2**SEL_WIDTH-1:0]   o_gnt,
    output logic [SEL_WIDTH-1:0]      o_sel,
    output logic                      o_valid,
    output logic                      o_timeout
);
    localparam int N = 2**SEL_WIDTH;
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_MAX - 1);

    typedef enum logic {ST_IDLE, ST_GRANT} state_t;

    state_t               state_q, state_d;
    logic [N-1:0]         gnt_q, gnt_d;
    logic [SEL_WIDTH-1:0] sel_q, sel_d;
    logic                 valid_q, valid_d;
    logic                 timeout_q, timeout_d;
    logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
    logic [15:0]          cnt_q, cnt_d;

    // Requests rotated so that bit 0 is the requester at the priority pointer.
    logic [N-1:0]         req_rot;
    logic [SEL_WIDTH-1:0] win_ofs;
    logic [SEL_WIDTH-1:0] winner;
    logic                 owner_req;
    logic                 hold_hit;

    for (genvar gi = 0; gi < N; gi++) begin : g_rot
        localparam logic [SEL_WIDTH-1:0] OFS = SEL_WIDTH'(gi);
        logic [SEL_WIDTH-1:0] rot_idx;
        assign rot_idx     = ptr_q + OFS;
        assign req_rot[gi] = i_req[rot_idx];
    end

    always_comb begin
        win_ofs = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_rot[k]) win_ofs = SEL_WIDTH'(k);
        end
    end

    assign winner    = ptr_q + win_ofs;
    assign owner_req = i_req[sel_q];
    assign hold_hit  = (HOLD_MAX != 0) && (cnt_q == HOLD_LAST);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|i_req) begin
                    state_d = ST_GRANT;
                    sel_d   = winner;
                    gnt_d   = N'(1) << winner;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_GRANT: begin
                if (!owner_req || i_done || hold_hit) begin
                    state_d   = ST_IDLE;
                    gnt_d     = '0;
                    valid_d   = 1'b0;
                    ptr_d     = sel_q + SEL_WIDTH'(1);
                    // A request drop wins over the limit; done does not mask it.
                    timeout_d = owner_req && hold_hit;
                end else if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            sel_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            ptr_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign o_gnt     = gnt_q;
    assign o_sel     = sel_q;
    assign o_valid   = valid_q;
    assign o_timeout = timeout_q;
endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Bench for rr_sel_arbiter: hand-derived vector table, corner sequences, and
// random stimulus checked against a behavioural model (HOLD_MAX=4 and HOLD_MAX=0).
module tb_rr_sel_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       done;
    logic [3:0] req;

    logic [3:0] gnt_a, gnt_b;
    logic [1:0] sel_a, sel_b;
    logic       val_a, val_b, to_a, to_b;

    rr_sel_arbiter #(.SEL_WIDTH(2), .HOLD_MAX(4)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_done(done),
        .o_gnt(gnt_a), .o_sel(sel_a), .o_valid(val_a), .o_timeout(to_a)
    );

    rr_sel_arbiter #(.SEL_WIDTH(2), .HOLD_MAX(0)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_done(done),
        .o_gnt(gnt_b), .o_sel(sel_b), .o_valid(val_b), .o_timeout(to_b)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: owner (-1 when idle), last owner shown on o_sel,
    // priority pointer, and number of cycles the current grant has been visible.
    typedef struct {
        int owner;
        int last;
        int ptr;
        int age;
        bit to;
    } mdl_t;

    function automatic mdl_t mdl_step(input mdl_t m, input logic [3:0] r,
                                      input logic d, input logic rs, input int hold);
        mdl_t n;
        bit expire;
        n    = m;
        n.to = 1'b0;
        if (rs) begin
            n.owner = -1; n.last = 0; n.ptr = 0; n.age = 0;
        end else if (m.owner < 0) begin
            for (int k = 0; k < N; k++) begin
                if (r[(m.ptr + k) % N]) begin
                    n.owner = (m.ptr + k) % N;
                    n.last  = n.owner;
                    n.age   = 1;
                    break;
                end
            end
        end else begin
            expire = (hold != 0) && (m.age == hold);
            if (!r[m.owner] || d || expire) begin
                n.to    = r[m.owner] && expire;
                n.ptr   = (m.owner + 1) % N;
                n.owner = -1;
            end else begin
                n.age = m.age + 1;
            end
        end
        return n;
    endfunction

    mdl_t ma, mb;

    task automatic check_dut(input string tag, input mdl_t m, input logic [3:0] g,
                             input logic [1:0] s, input logic v, input logic t);
        check({tag, "_valid"}, 32'(v), 32'(m.owner >= 0));
        check({tag, "_sel"}, 32'(s), 32'(m.last));
        check({tag, "_gnt"}, 32'(g), (m.owner >= 0) ? (32'd1 << m.owner) : 32'd0);
        check({tag, "_timeout"}, 32'(t), 32'(m.to));
        check({tag, "_onehot"}, 32'($onehot0(g)), 32'd1);
        check({tag, "_gnt_vs_sel"}, 32'(g), v ? (32'd1 << s) : 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        ma = mdl_step(ma, req, done, rst, 4);
        mb = mdl_step(mb, req, done, rst, 0);
        #1;
        check_dut("A", ma, gnt_a, sel_a, val_a, to_a);
        check_dut("B", mb, gnt_b, sel_b, val_b, to_b);
        $display("cyc rst=%b req=%b done=%b | A v=%b s=%0d g=%b t=%b | B v=%b s=%0d g=%b t=%b",
                 rst, req, done, val_a, sel_a, gnt_a, to_a, val_b, sel_b, gnt_b, to_b);
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       done;
        logic       val;
        logic [1:0] sel;
        logic [3:0] gnt;
        logic       to;
    } vec_t;

    function automatic vec_t mk(input logic rs, input logic [3:0] r, input logic d,
                                input logic v, input logic [1:0] s, input logic [3:0] g,
                                input logic t);
        vec_t x;
        x.rst = rs; x.req = r; x.done = d; x.val = v; x.sel = s; x.gnt = g; x.to = t;
        return x;
    endfunction

    vec_t tbl[32];

    initial begin
        int vb_cnt;
        int tb_cnt;
        rst  = 1'b1;
        req  = '0;
        done = 1'b0;
        ma   = '{owner: -1, last: 0, ptr: 0, age: 0, to: 1'b0};
        mb   = ma;

        // Expectations for HOLD_MAX=4 instance, derived by hand.
        tbl[0]  = mk(1, 4'b0000, 0, 0, 0, 4'b0000, 0);
        tbl[1]  = mk(0, 4'b0100, 0, 1, 2, 4'b0100, 0);
        tbl[2]  = mk(0, 4'b0100, 0, 1, 2, 4'b0100, 0);
        tbl[3]  = mk(1, 4'b0100, 0, 0, 0, 4'b0000, 0);
        tbl[4]  = mk(0, 4'b0110, 0, 1, 1, 4'b0010, 0);
        tbl[5]  = mk(0, 4'b0110, 1, 0, 1, 4'b0000, 0);
        tbl[6]  = mk(0, 4'b0011, 0, 1, 0, 4'b0001, 0);
        tbl[7]  = mk(0, 4'b0011, 0, 1, 0, 4'b0001, 0);
        tbl[8]  = mk(0, 4'b0010, 0, 0, 0, 4'b0000, 0);
        tbl[9]  = mk(0, 4'b1111, 0, 1, 1, 4'b0010, 0);
        tbl[10] = mk(0, 4'b1111, 1, 0, 1, 4'b0000, 0);
        tbl[11] = mk(0, 4'b1111, 0, 1, 2, 4'b0100, 0);
        tbl[12] = mk(0, 4'b1111, 1, 0, 2, 4'b0000, 0);
        tbl[13] = mk(0, 4'b1111, 0, 1, 3, 4'b1000, 0);
        tbl[14] = mk(0, 4'b1111, 1, 0, 3, 4'b0000, 0);
        tbl[15] = mk(0, 4'b1111, 0, 1, 0, 4'b0001, 0);
        tbl[16] = mk(0, 4'b1111, 1, 0, 0, 4'b0000, 0);
        tbl[17] = mk(0, 4'b1111, 0, 1, 1, 4'b0010, 0);
        tbl[18] = mk(0, 4'b1111, 1, 0, 1, 4'b0000, 0);
        tbl[19] = mk(0, 4'b1000, 0, 1, 3, 4'b1000, 0);
        tbl[20] = mk(0, 4'b1000, 0, 1, 3, 4'b1000, 0);
        tbl[21] = mk(0, 4'b1000, 0, 1, 3, 4'b1000, 0);
        tbl[22] = mk(0, 4'b1000, 0, 1, 3, 4'b1000, 0);
        tbl[23] = mk(0, 4'b1000, 0, 0, 3, 4'b0000, 1);
        tbl[24] = mk(0, 4'b1000, 0, 1, 3, 4'b1000, 0);
        tbl[25] = mk(0, 4'b1000, 0, 1, 3, 4'b1000, 0);
        tbl[26] = mk(0, 4'b1000, 0, 1, 3, 4'b1000, 0);
        tbl[27] = mk(0, 4'b1000, 0, 1, 3, 4'b1000, 0);
        tbl[28] = mk(0, 4'b1000, 1, 0, 3, 4'b0000, 1);
        tbl[29] = mk(0, 4'b0000, 0, 0, 3, 4'b0000, 0);
        tbl[30] = mk(0, 4'b0000, 0, 0, 3, 4'b0000, 0);
        tbl[31] = mk(0, 4'b0001, 0, 1, 0, 4'b0001, 0);

        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            rst  = tbl[i].rst;
            req  = tbl[i].req;
            done = tbl[i].done;
            tick();
            check($sformatf("row%0d_valid", i), 32'(val_a), 32'(tbl[i].val));
            check($sformatf("row%0d_sel", i), 32'(sel_a), 32'(tbl[i].sel));
            check($sformatf("row%0d_gnt", i), 32'(gnt_a), 32'(tbl[i].gnt));
            check($sformatf("row%0d_timeout", i), 32'(to_a), 32'(tbl[i].to));
        end

        // Unlimited hold: one requester for 100 cycles never times out.
        rst = 1'b1; req = '0; done = 1'b0;
        tick();
        rst = 1'b0; req = 4'b0001;
        vb_cnt = 0;
        tb_cnt = 0;
        repeat (100) begin
            tick();
            if (val_b) vb_cnt++;
            if (to_b) tb_cnt++;
        end
        check("hold0_valid_cycles", 32'(vb_cnt), 32'd100);
        check("hold0_timeouts", 32'(tb_cnt), 32'd0);

        // Random traffic against the model; requests tend to persist.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            done = ($urandom_range(0, 5) == 0);
            rst  = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
